// File: rtl/ds4_pkg.sv
// rtl/ds4_pkg.sv - shared widths and state encodings for the DS4 selector and its arbiter
package ds4_pkg;

  localparam int DS4_WIDTH = 32;
  localparam int DS4_IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/ds4.sv
// rtl/ds4.sv - 4-to-1 WIDTH-bit data selector
module ds4
  import ds4_pkg::*;
#(
  parameter int WIDTH = DS4_WIDTH
) (
  input  logic [DS4_IDX_W-1:0] select,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic [WIDTH-1:0]     data3,
  input  logic [WIDTH-1:0]     data4,
  output logic [WIDTH-1:0]     data_out
);

  always_comb begin
    data_out = data1;
    case (select)
      2'd0:    data_out = data1;
      2'd1:    data_out = data2;
      2'd2:    data_out = data3;
      2'd3:    data_out = data4;
      default: data_out = data1;
    endcase
  end

endmodule

// File: rtl/ds4_rr_pick.sv
// rtl/ds4_rr_pick.sv - rotating-priority winner search starting at ptr
module ds4_rr_pick
  import ds4_pkg::*;
(
  input  logic [3:0]           req_valid,
  input  logic [DS4_IDX_W-1:0] ptr,
  output logic                 any,
  output logic [DS4_IDX_W-1:0] winner
);

  logic [DS4_IDX_W-1:0] idx;

  // Scan from the lowest priority upward so the last hit is the highest-priority requester.
  always_comb begin
    any    = |req_valid;
    winner = ptr;
    idx    = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + DS4_IDX_W'(k);
      if (req_valid[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ds4_rr_arbiter.sv
// rtl/ds4_rr_arbiter.sv - round-robin arbiter sequencing four requesters through DS4
// into a one-deep output register with a valid/ready downstream handshake.
module ds4_rr_arbiter
  import ds4_pkg::*;
#(
  parameter int WIDTH = DS4_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req_valid,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic [WIDTH-1:0]     data3,
  input  logic [WIDTH-1:0]     data4,
  output logic [3:0]           req_ready,
  output logic [DS4_IDX_W-1:0] select,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [DS4_IDX_W-1:0] out_src,
  input  logic                 out_ready,
  output logic [15:0]          grant_cnt
);

  state_e               state_q, state_d;
  logic [DS4_IDX_W-1:0] ptr_q, ptr_d;
  logic [DS4_IDX_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [DS4_IDX_W-1:0] src_q, src_d;
  logic [15:0]          cnt_q, cnt_d;

  logic                 any;
  logic [DS4_IDX_W-1:0] winner;
  logic                 can_accept;
  logic                 accept;
  logic [WIDTH-1:0]     ds4_out;

  ds4_rr_pick u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .any       (any),
    .winner    (winner)
  );

  ds4 #(.WIDTH(WIDTH)) u_ds4 (
    .select   (select),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .data4    (data4),
    .data_out (ds4_out)
  );

  // A held word being consumed frees the register in the same cycle, so accept never bubbles.
  assign can_accept = (state_q == ST_IDLE) || out_ready;
  assign accept     = can_accept && any && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (out_ready && !accept) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_HOLD);
    req_ready = accept ? (4'b0001 << winner) : 4'b0000;
    select    = accept ? winner : sel_q;
  end

  always_comb begin
    ptr_d  = ptr_q;
    sel_d  = sel_q;
    data_d = data_q;
    src_d  = src_q;
    cnt_d  = cnt_q;
    if (accept) begin
      ptr_d  = winner + DS4_IDX_W'(1);
      sel_d  = winner;
      data_d = ds4_out;
      src_d  = winner;
      cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      sel_q  <= '0;
      data_q <= '0;
      src_q  <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      src_q  <= src_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_src   = src_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_ds4_rr_arbiter.sv
// tb/tb_ds4_rr_arbiter.sv - table-driven scoreboard bench for ds4_rr_arbiter
module tb_ds4_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] data1, data2, data3, data4;
  logic [3:0]  req_ready;
  logic [1:0]  select;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic [15:0] grant_cnt;

  always #5 clk = ~clk;

  ds4_rr_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .req_ready (req_ready),
    .select    (select),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .grant_cnt (grant_cnt)
  );

  typedef struct {
    logic       rst;
    int         dset;
    logic [3:0] rv;
    logic       ordy;
    logic [3:0] exp_rr;
    logic [1:0] exp_sel;
    logic       exp_ov;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
  } word_t;

  vec_t        vecs[$];
  word_t       sb[$];
  word_t       last_w;
  logic [31:0] dsets[2][4];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic r, input int ds, input logic [3:0] rv, input logic ordy,
                              input logic [3:0] err, input logic [1:0] es, input logic eov);
    vec_t v;
    v.rst = r; v.dset = ds; v.rv = rv; v.ordy = ordy;
    v.exp_rr = err; v.exp_sel = es; v.exp_ov = eov;
    vecs.push_back(v);
  endfunction

  task automatic apply(input int n, input vec_t v);
    word_t w;
    rst       = v.rst;
    req_valid = v.rv;
    out_ready = v.ordy;
    data1 = dsets[v.dset][0]; data2 = dsets[v.dset][1];
    data3 = dsets[v.dset][2]; data4 = dsets[v.dset][3];
    @(negedge clk);
    chk($sformatf("row%0d req_ready", n), 32'(req_ready), 32'(v.exp_rr));
    chk($sformatf("row%0d select", n), 32'(select), 32'(v.exp_sel));
    @(posedge clk);
    if (v.rst) begin
      exp_cnt = 16'd0;
      sb.delete();
    end else if (v.exp_rr != 4'd0) begin
      w.data = dsets[v.dset][v.exp_sel];
      w.src  = v.exp_sel;
      sb.push_back(w);
      exp_cnt = exp_cnt + 16'd1;
    end
    #1;
    chk($sformatf("row%0d out_valid", n), 32'(out_valid), 32'(v.exp_ov));
    chk($sformatf("row%0d grant_cnt", n), 32'(grant_cnt), 32'(exp_cnt));
    if (v.rst) begin
      chk($sformatf("row%0d rst out_data", n), out_data, 32'd0);
      chk($sformatf("row%0d rst out_src", n), 32'(out_src), 32'd0);
    end else if (v.exp_rr != 4'd0) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL row%0d scoreboard empty", n);
      end else begin
        last_w = sb.pop_front();
        chk($sformatf("row%0d out_data", n), out_data, last_w.data);
        chk($sformatf("row%0d out_src", n), 32'(out_src), 32'(last_w.src));
      end
    end else if (v.exp_ov) begin
      chk($sformatf("row%0d hold out_data", n), out_data, last_w.data);
      chk($sformatf("row%0d hold out_src", n), 32'(out_src), 32'(last_w.src));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dsets[0][0] = 32'h33; dsets[0][1] = 32'hF0; dsets[0][2] = 32'h0F; dsets[0][3] = 32'h55;
    dsets[1][0] = 32'hFF; dsets[1][1] = 32'hEF; dsets[1][2] = 32'h81; dsets[1][3] = 32'hCC;
    last_w.data = 32'd0; last_w.src = 2'd0;

    // reset then idle
    add(1, 0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(1, 0, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 2'd0, 0);
    // single request
    add(0, 0, 4'b0100, 1, 4'b0100, 2'd2, 1);
    add(0, 0, 4'b0000, 1, 4'b0000, 2'd2, 0);
    // full contention from reset
    add(1, 0, 4'b0000, 0, 4'b0000, 2'd2, 0);
    add(0, 0, 4'b1111, 1, 4'b0001, 2'd0, 1);
    add(0, 0, 4'b1111, 1, 4'b0010, 2'd1, 1);
    add(0, 0, 4'b1111, 1, 4'b0100, 2'd2, 1);
    add(0, 0, 4'b1111, 1, 4'b1000, 2'd3, 1);
    add(0, 0, 4'b1111, 1, 4'b0001, 2'd0, 1);
    add(0, 0, 4'b0000, 1, 4'b0000, 2'd0, 0);
    // backpressure
    add(1, 1, 4'b0000, 0, 4'b0000, 2'd0, 0);
    add(0, 1, 4'b0011, 1, 4'b0001, 2'd0, 1);
    add(0, 1, 4'b0011, 0, 4'b0000, 2'd0, 1);
    add(0, 1, 4'b0011, 0, 4'b0000, 2'd0, 1);
    add(0, 1, 4'b0011, 0, 4'b0000, 2'd0, 1);
    add(0, 1, 4'b0011, 1, 4'b0010, 2'd1, 1);
    add(0, 1, 4'b0000, 1, 4'b0000, 2'd1, 0);
    // pointer wrap and drop
    add(0, 0, 4'b1000, 1, 4'b1000, 2'd3, 1);
    add(0, 0, 4'b1010, 1, 4'b0010, 2'd1, 1);
    add(0, 0, 4'b1000, 0, 4'b0000, 2'd1, 1);
    add(0, 0, 4'b0000, 1, 4'b0000, 2'd1, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 2'd1, 0);
    add(0, 0, 4'b0101, 1, 4'b0100, 2'd2, 1);
    add(0, 0, 4'b0101, 1, 4'b0001, 2'd0, 1);
    add(0, 0, 4'b0000, 1, 4'b0000, 2'd0, 0);
    // reset mid-hold
    add(0, 1, 4'b0001, 1, 4'b0001, 2'd0, 1);
    add(0, 1, 4'b0000, 0, 4'b0000, 2'd0, 1);
    add(1, 1, 4'b1111, 0, 4'b0000, 2'd0, 0);
    add(0, 1, 4'b0000, 1, 4'b0000, 2'd0, 0);
    add(0, 1, 4'b1111, 1, 4'b0001, 2'd0, 1);

    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b0;
    data1 = 32'd0; data2 = 32'd0; data3 = 32'd0; data4 = 32'd0;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // grant counter wrap under sustained full-rate contention
    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 4'b1111;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap grant_cnt max", 32'(grant_cnt), 32'h0000FFFF);
    chk("wrap out_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    chk("wrap grant_cnt zero", 32'(grant_cnt), 32'd0);
    chk("wrap out_src", 32'(out_src), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
